// File: rtl/drum_pipe_mult.sv
// Three-stage pipelined DRUM approximate multiplier with exact-mode bypass,
// optional two's-complement operands, tag sideband and valid/ready handshake.
module drum_pipe_mult #(
  parameter int unsigned K      = 6,
  parameter int unsigned N      = 16,
  parameter int unsigned M      = 16,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic             in_approx,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W   = N + M;
  localparam int unsigned L   = (N > M) ? N : M;
  localparam int unsigned LW  = $clog2(L);
  localparam int unsigned SHW = LW + 1;
  localparam int unsigned PW  = 2 * K;
  localparam bit IS_SIGNED    = (SIGNED != 0);

  // Index of the most significant set bit; 0 for a zero input.
  function automatic logic [LW-1:0] lod(input logic [L-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(L); i++) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  // DRUM truncation: keep K bits from the leading one, force the LSB to 1.
  function automatic logic [K+LW-1:0] drum_trunc(input logic [L-1:0] mag);
    logic [LW-1:0] t;
    logic [LW-1:0] p;
    logic [K-1:0]  mm;
    t = lod(mag);
    if (t <= LW'(K - 1)) begin
      p  = '0;
      mm = mag[K-1:0];
    end else begin
      p  = t - LW'(K - 1);
      mm = K'(mag >> p) | K'(1);
    end
    return {mm, p};
  endfunction

  logic en;

  // Stage 1 combinational: magnitudes, sign, leading-one truncation
  logic [N-1:0]  mag_a_c;
  logic [M-1:0]  mag_b_c;
  logic          sign_c;
  logic [K-1:0]  mm_c;
  logic [K-1:0]  nn_c;
  logic [LW-1:0] p_c;
  logic [LW-1:0] q_c;

  always_comb begin
    mag_a_c = in_a;
    mag_b_c = in_b;
    if (IS_SIGNED && in_a[N-1]) mag_a_c = -in_a;
    if (IS_SIGNED && in_b[M-1]) mag_b_c = -in_b;
    sign_c     = IS_SIGNED & (in_a[N-1] ^ in_b[M-1]);
    {mm_c, p_c} = drum_trunc(L'(mag_a_c));
    {nn_c, q_c} = drum_trunc(L'(mag_b_c));
  end

  // Stage 1 registers
  logic             v1;
  logic             s1;
  logic             ap1;
  logic [TAG_W-1:0] tag1;
  logic [N-1:0]     mag_a1;
  logic [M-1:0]     mag_b1;
  logic [K-1:0]     mm1;
  logic [K-1:0]     nn1;
  logic [LW-1:0]    p1;
  logic [LW-1:0]    q1;

  // Stage 2 combinational: approximate or exact product plus total shift
  logic [PW-1:0]  prod_apx_c;
  logic [W-1:0]   prod_ext_c;
  logic [W-1:0]   prod_c;
  logic [SHW-1:0] sh_c;

  always_comb begin
    prod_apx_c = PW'(mm1) * PW'(nn1);
    prod_ext_c = W'(mag_a1) * W'(mag_b1);
    prod_c     = ap1 ? W'(prod_apx_c) : prod_ext_c;
    sh_c       = ap1 ? (SHW'(p1) + SHW'(q1)) : '0;
  end

  // Stage 2 registers
  logic             v2;
  logic             s2;
  logic [TAG_W-1:0] tag2;
  logic [W-1:0]     prod2;
  logic [SHW-1:0]   sh2;

  // Stage 3 combinational: rescale and reapply sign (zero stays unsigned)
  logic [W-1:0] mag_r_c;
  logic [W-1:0] res_c;

  always_comb begin
    mag_r_c = prod2 << sh2;
    res_c   = (IS_SIGNED && s2 && (mag_r_c != '0)) ? -mag_r_c : mag_r_c;
  end

  // Whole pipe advances together unless the output is blocked
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Valid bits and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_r   <= res_c;
        out_tag <= tag2;
      end
    end
  end

  // Datapath registers; contents only matter when the matching valid bit is set
  always_ff @(posedge clk) begin
    if (en) begin
      if (in_valid) begin
        s1     <= sign_c;
        ap1    <= in_approx;
        tag1   <= in_tag;
        mag_a1 <= mag_a_c;
        mag_b1 <= mag_b_c;
        mm1    <= mm_c;
        nn1    <= nn_c;
        p1     <= p_c;
        q1     <= q_c;
      end
      if (v1) begin
        s2    <= s1;
        tag2  <= tag1;
        prod2 <= prod_c;
        sh2   <= sh_c;
      end
    end
  end

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Bench for drum_pipe_mult: unsigned and signed instances driven in lockstep,
// checked against a value-level DRUM reference model and a FIFO scoreboard.
module tb_drum_pipe_mult;

  localparam int unsigned K = 6;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_approx;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready_u, out_valid_u;
  logic [31:0] out_r_u;
  logic [3:0]  out_tag_u;
  logic        in_ready_s, out_valid_s;
  logic [31:0] out_r_s;
  logic [3:0]  out_tag_s;

  drum_pipe_mult #(.K(6), .N(16), .M(16), .SIGNED(0), .TAG_W(4)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_tag(in_tag),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_r(out_r_u), .out_tag(out_tag_u)
  );

  drum_pipe_mult #(.K(6), .N(16), .M(16), .SIGNED(1), .TAG_W(4)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_r(out_r_s), .out_tag(out_tag_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ru;
    logic [31:0] rs;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   acc_last = 1'b0;

  // Reference: keep K bits from the leading one with LSB forced, scaled back up
  function automatic longint drum_val(input longint x);
    int     t;
    longint p;
    if (x < (longint'(1) << K)) return x;
    t = 0;
    for (int i = 0; i < 17; i++) if (((x >> i) & 1) != 0) t = i;
    p = longint'(t) - longint'(K) + 1;
    return ((x >> p) | 1) << p;
  endfunction

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic apx, input bit sgn);
    longint ma, mb, pr;
    bit     neg;
    ma  = (sgn && a[15]) ? 65536 - longint'(a) : longint'(a);
    mb  = (sgn && b[15]) ? 65536 - longint'(b) : longint'(b);
    neg = sgn && (a[15] ^ b[15]);
    pr  = apx ? drum_val(ma) * drum_val(mb) : ma * mb;
    if (neg && pr != 0) pr = (longint'(1) << 32) - pr;
    return 32'(pr);
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'(1 + $urandom_range(0, 62));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score outputs/accepts for this cycle, advance past the edge
  task automatic tick();
    bit   acc, outx;
    exp_t e;
    #1;
    acc  = !rst && in_valid && in_ready_u;
    outx = !rst && out_valid_u && out_ready;
    if (!rst && out_valid_u) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid_u), 64'(0));
      end else begin
        chk("r_uns", 64'(out_r_u), 64'(q[0].ru));
        chk("r_sgn", 64'(out_r_s), 64'(q[0].rs));
        chk("tag_uns", 64'(out_tag_u), 64'(q[0].tag));
        chk("tag_sgn", 64'(out_tag_s), 64'(q[0].tag));
      end
    end
    if (outx && q.size() > 0) begin
      void'(q.pop_front());
      n_out++;
    end
    if (acc) begin
      e.ru  = model(in_a, in_b, in_approx, 1'b0);
      e.rs  = model(in_a, in_b, in_approx, 1'b1);
      e.tag = in_tag;
      q.push_back(e);
    end
    acc_last = acc;
    @(posedge clk);
    #1;
    if (rst) q.delete();
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic apx, input logic [3:0] tag,
                         input logic [31:0] exp_u, input logic [31:0] exp_s);
    int w;
    in_a = a; in_b = b; in_approx = apx; in_tag = tag; in_valid = 1'b1;
    tick();
    chk({name, "_acc"}, 64'(acc_last), 64'(1));
    in_valid = 1'b0;
    w = 0;
    while (!out_valid_u && w < 10) begin
      tick();
      w++;
    end
    chk({name, "_uns"}, 64'(out_r_u), 64'(exp_u));
    chk({name, "_sgn"}, 64'(out_r_s), 64'(exp_s));
    tick();
  endtask

  initial begin
    int idx, cyc, w, base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_approx = 1'b0; in_tag = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(out_valid_u), 64'(0));
    chk("reset_valid_s", 64'(out_valid_s), 64'(0));
    chk("reset_r", 64'(out_r_u), 64'(0));
    chk("reset_tag", 64'(out_tag_u), 64'(0));
    chk("reset_ready", 64'(in_ready_u), 64'(1));

    // Latency: accepted pair appears exactly three cycles later
    in_a = 16'd3; in_b = 16'd5; in_approx = 1'b1; in_tag = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_c1", 64'(out_valid_u), 64'(0));
    tick();
    chk("lat_c2", 64'(out_valid_u), 64'(0));
    tick();
    chk("lat_c3", 64'(out_valid_u), 64'(1));
    chk("lat_r", 64'(out_r_u), 64'(15));
    chk("lat_tag", 64'(out_tag_u), 64'(1));
    tick();

    run_one("d_1000_apx",  16'd1000, 16'd1000, 1'b1, 4'd2, 32'h000F8100, 32'h000F8100);
    run_one("d_1000_ext",  16'd1000, 16'd1000, 1'b0, 4'd3, 32'd1000000,  32'd1000000);
    run_one("d_ffff_apx",  16'hFFFF, 16'hFFFF, 1'b1, 4'd4, 32'hF8100000, 32'h00000001);
    run_one("d_zero_a",    16'h0000, 16'hFFFF, 1'b1, 4'd5, 32'h0,        32'h0);
    run_one("d_zero_b",    16'h1234, 16'h0000, 1'b0, 4'd6, 32'h0,        32'h0);
    run_one("d_neg1000",   16'hFC18, 16'd1000, 1'b1, 4'd7, 32'h03E04000, 32'hFFF07F00);
    run_one("d_minneg_ex", 16'h8000, 16'd1,    1'b0, 4'd8, 32'h00008000, 32'hFFFF8000);
    run_one("d_minneg_ap", 16'h8000, 16'd1,    1'b1, 4'd9, 32'h00008400, 32'hFFFF7C00);

    // Eight back-to-back pairs with a four-cycle output stall mid-stream
    base = n_out;
    idx = 0;
    cyc = 0;
    in_a = pick16(); in_b = pick16(); in_approx = 1'($urandom_range(0, 1));
    while ((idx < 8 || q.size() > 0) && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid  = (idx < 8);
      in_tag    = 4'(idx);
      if (cyc == 5) begin
        #1;
        chk("stall_ready", 64'(in_ready_u), 64'(0));
        chk("stall_valid", 64'(out_valid_u), 64'(1));
      end
      tick();
      if (acc_last) begin
        idx++;
        in_a = pick16(); in_b = pick16(); in_approx = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(n_out - base), 64'(8));
    chk("stream_empty", 64'(q.size()), 64'(0));

    // Reset with three pairs in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = pick16(); in_b = pick16(); in_approx = 1'b1; in_tag = 4'(10 + i);
      in_valid = 1'b1;
      tick();
      chk("inflight_acc", 64'(acc_last), 64'(1));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_valid", 64'(out_valid_u), 64'(0));
    chk("midrst_valid_s", 64'(out_valid_s), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale", 64'(out_valid_u), 64'(0));
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = pick16();
      in_b      = pick16();
      in_approx = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (q.size() > 0 && w < 20) begin
      tick();
      w++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    tick();
    chk("final_idle", 64'(out_valid_u), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
